// File: rtl/fft_sm_sample_loader.sv
// Sweeps the FFT initial-sample LUT and streams each sample with its index over valid/ready.
// Define FFT_SM_LOADER_BITREV_EN to fetch samples in bit-reversed address order.
module fft_sm_sample_loader #(
    parameter int N_LOG2 = 8,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] lut_n,
    input  logic [DATA_W-1:0] lut_x_re,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [N_LOG2-1:0] out_idx,
    output logic              out_last
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [N_LOG2-1:0] LAST_IDX = '1;

    // Sequence number k -> LUT address; only the low N_LOG2 bits are ever set.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [N_LOG2-1:0] k);
        logic [ADDR_W-1:0] a;
        a = '0;
`ifdef FFT_SM_LOADER_BITREV_EN
        for (int i = 0; i < N_LOG2; i++) begin
            a[i] = k[N_LOG2-1-i];
        end
`else
        a[N_LOG2-1:0] = k;
`endif
        return a;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [N_LOG2-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] lut_n_q, lut_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [N_LOG2-1:0] idx_q, idx_d;
    logic              last_q, last_d;
    logic              load;

    // The output register can take a new sample when empty or being drained this cycle.
    assign load = !valid_q || out_ready;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        lut_n_d = lut_n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE) begin
                    lut_n_d = '0;
                    state_d = ST_IDLE;
                end
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    lut_n_d = addr_of('0);
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (load) begin
                    data_d  = lut_x_re;
                    idx_d   = cnt_q;
                    last_d  = (cnt_q == LAST_IDX);
                    valid_d = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d   = cnt_q + N_LOG2'(1);
                        lut_n_d = addr_of(cnt_q + N_LOG2'(1));
                    end
                end
            end
            ST_DRAIN: begin
                // out_valid is always high here, so out_ready alone marks the final handshake.
                if (out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lut_n_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lut_n_q <= lut_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign lut_n     = lut_n_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_fft_sm_sample_loader.sv
// Scoreboard bench for fft_sm_sample_loader: LUT model, random backpressure, restarts and resets.
// Honours FFT_SM_LOADER_BITREV_EN to predict bit-reversed fetch order.
module tb_fft_sm_sample_loader;

    localparam int N_LOG2 = 8;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int N      = 1 << N_LOG2;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [N_LOG2-1:0] idx;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] lut_n;
    logic [DATA_W-1:0] lut_x_re;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [N_LOG2-1:0] out_idx;
    logic              out_last;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fft_sm_sample_loader #(
        .N_LOG2(N_LOG2),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .lut_n    (lut_n),
        .lut_x_re (lut_x_re),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_last (out_last)
    );

    // LUT model: known points from the sample table, hashed filler elsewhere.
    function automatic logic [DATA_W-1:0] lut_val(input logic [ADDR_W-1:0] a);
        case (a)
            10'd0:   return 32'h00000000;
            10'd1:   return 32'h000008D1;
            10'd2:   return 32'hFFFFEFE5;
            10'd64:  return 32'hFFFFF665;
            10'd128: return 32'hFFFFFF36;
            10'd255: return 32'h00000334;
            default: return (32'(a) * 32'h9E3779B1) ^ 32'h13572468;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] exp_addr(input logic [N_LOG2-1:0] k);
        logic [ADDR_W-1:0] a;
        a = '0;
`ifdef FFT_SM_LOADER_BITREV_EN
        for (int i = 0; i < N_LOG2; i++) a[i] = k[N_LOG2-1-i];
`else
        a[N_LOG2-1:0] = k;
`endif
        return a;
    endfunction

    always_comb lut_x_re = lut_val(lut_n);

    // Drives n_sweeps sweeps from IDLE and checks every beat against the scoreboard.
    task automatic run_sweeps(input string name, input int n_sweeps, input int ready_pct,
                              input bit stall_last, input bit start_in_run,
                              input bit start_in_drain, input int restart_gap);
        beat_t             sb[$];
        beat_t             e;
        int                cyc = 0, started = 0, beats = 0, dones = 0;
        int                last_hs = -10, start_cyc = -10, restart_at = -1, post_end = -1;
        bit                stalled_once = 0, prev_stall = 0, timed_out = 1;
        logic [DATA_W-1:0] p_data;
        logic [N_LOG2-1:0] p_idx;
        logic              p_last;
        logic [ADDR_W-1:0] p_lut_n;

        while (cyc < 4000) begin
            if (cyc == start_cyc + 1) begin
                total++;
                if (busy !== 1'b1 || out_valid !== 1'b0 || lut_n !== exp_addr('0)) begin
                    bad++;
                    $display("FAIL %s start_latency: busy=%b valid=%b lut_n=%0d want busy=1 valid=0 lut_n=%0d",
                             name, busy, out_valid, lut_n, exp_addr('0));
                end
            end
            if (cyc == start_cyc + 2) begin
                total++;
                if (out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL %s first_valid: got %b want 1", name, out_valid);
                end
            end
            total++;
            if (lut_n[ADDR_W-1:N_LOG2] !== '0) begin
                bad++;
                $display("FAIL %s lut_n_range: got %0d want < %0d", name, lut_n, N);
            end
            if (out_valid) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s busy_with_valid: got %b want 1", name, busy);
                end
            end
            if (prev_stall) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== p_data || out_idx !== p_idx ||
                    out_last !== p_last || lut_n !== p_lut_n) begin
                    bad++;
                    $display("FAIL %s stall_hold: v=%b d=%h i=%0d l=%b n=%0d want v=1 d=%h i=%0d l=%b n=%0d",
                             name, out_valid, out_data, out_idx, out_last, lut_n,
                             p_data, p_idx, p_last, p_lut_n);
                end
            end
            if (done) begin
                dones++;
                total++;
                if (cyc != last_hs + 1 || sb.size() != 0 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL %s done_timing: cyc=%0d last_hs=%0d pending=%0d busy=%b want cyc=%0d pending=0 busy=0",
                             name, cyc, last_hs, sb.size(), busy, last_hs + 1);
                end
                stalled_once = 0;
                if (started < n_sweeps) restart_at = cyc + restart_gap;
                else post_end = cyc + 4;
            end else if (post_end >= 0) begin
                total++;
                if (busy !== 1'b0 || out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL %s idle_after_done: busy=%b valid=%b want 0 0", name, busy, out_valid);
                end
            end
            if (post_end >= 0 && cyc == post_end) begin
                timed_out = 0;
                break;
            end

            start = 1'b0;
            if (cyc == 0 || cyc == restart_at) begin
                start     = 1'b1;
                start_cyc = cyc;
                started++;
                for (int k = 0; k < N; k++) begin
                    e.data = lut_val(exp_addr(N_LOG2'(k)));
                    e.idx  = N_LOG2'(k);
                    e.last = (k == N - 1);
                    sb.push_back(e);
                end
            end
            if (start_in_run && out_valid && out_idx == N_LOG2'(128)) start = 1'b1;
            if (start_in_drain && out_valid && out_last) start = 1'b1;
            out_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
            if (stall_last && out_valid && out_last && !stalled_once) begin
                out_ready    = 1'b0;
                stalled_once = 1;
            end

            if (out_valid && out_ready) begin
                beats++;
                last_hs = cyc;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL %s extra_beat: idx=%0d with empty scoreboard", name, out_idx);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data || out_idx !== e.idx || out_last !== e.last) begin
                        bad++;
                        $display("FAIL %s beat: d=%h i=%0d l=%b want d=%h i=%0d l=%b",
                                 name, out_data, out_idx, out_last, e.data, e.idx, e.last);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            p_data     = out_data;
            p_idx      = out_idx;
            p_last     = out_last;
            p_lut_n    = lut_n;
            cyc++;
            @(negedge clk);
        end
        start     = 1'b0;
        out_ready = 1'b0;
        total++;
        if (timed_out || beats != N * n_sweeps || dones != n_sweeps || sb.size() != 0) begin
            bad++;
            $display("FAIL %s totals: timeout=%b beats=%0d dones=%0d pending=%0d want timeout=0 beats=%0d dones=%0d pending=0",
                     name, timed_out, beats, dones, sb.size(), N * n_sweeps, n_sweeps);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || lut_n !== '0 || out_valid !== 1'b0 ||
            out_data !== '0 || out_idx !== '0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b lut_n=%0d v=%b d=%h i=%0d l=%b want all 0",
                     busy, done, lut_n, out_valid, out_data, out_idx, out_last);
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b valid=%b done=%b want 0 0 0", busy, out_valid, done);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_natural();
        run_sweeps("single", 1, 100, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        run_sweeps("backpressure", 1, 50, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_start_ignored();
        run_sweeps("start_ignored", 1, 100, 1'b1, 1'b1, 1'b1, 0);
    endtask

    task automatic test_start_in_done();
        run_sweeps("start_in_done", 2, 50, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset_mid_sweep();
        int  cyc = 0;
        bit  hit = 0;
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < 400 && !hit) begin
            if (out_valid && out_idx == N_LOG2'(100)) hit = 1;
            else begin
                cyc++;
                @(negedge clk);
            end
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL rst_mid reach_beat100: got no beat 100 within %0d cycles", cyc);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || lut_n !== '0 || out_valid !== 1'b0 ||
            out_data !== '0 || out_idx !== '0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid outputs: busy=%b done=%b lut_n=%0d v=%b d=%h i=%0d l=%b want all 0",
                     busy, done, lut_n, out_valid, out_data, out_idx, out_last);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid quiet: done=%b busy=%b valid=%b want 0 0 0", done, busy, out_valid);
            end
        end
        out_ready = 1'b0;
        run_sweeps("after_rst", 1, 100, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        run_sweeps("back_to_back", 2, 100, 1'b0, 1'b0, 1'b0, 1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_natural();
        test_backpressure();
        test_start_ignored();
        test_start_in_done();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
